// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider ratio control front-end.
package div_ctrl_pkg;

    // Default width of the divider ratio bus.
    localparam int DIV_RATIO_WIDTH = 8;

    // Cycles spent in SETTLE; the divider registers its ratio one cycle after load.
    localparam int DIV_SETTLE_CYCLES = 2;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_RUN      = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_LOAD     = 3'd3,
        ST_SETTLE   = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_wait_timer.sv
// Loadable down-counter with a zero flag, shared by the DRAIN and SETTLE waits.
// The counter holds at zero until reloaded.
module div_wait_timer #(
    parameter int W = 3
) (
    input  logic         i_ref_clk,
    input  logic         i_rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down toward zero and stop there.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/div_ratio_ctrl.sv
// Ratio update sequencer in front of the integer clock divider.
// Every ratio change takes the divider offline (DRAIN), loads the ratio (LOAD),
// waits for the divider to register it (SETTLE) and then restores the enable.
// Optional feature: define DIV_RATIO_RANGE_CHECK_EN to reject ratios outside
// [MIN_RATIO, MAX_RATIO]; rejected requests complete the handshake, pulse
// o_cfg_err and leave everything else untouched.
// Handshake: a request transfers on a rising edge where i_cfg_valid and
// o_cfg_ready are both high; the requester holds valid and data until then.
module div_ratio_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int                     RATIO_WIDTH  = DIV_RATIO_WIDTH,
    parameter logic [RATIO_WIDTH-1:0] RESET_RATIO  = RATIO_WIDTH'(1),
    parameter int                     DRAIN_CYCLES = 4,
    parameter int                     MIN_RATIO    = 2,
    parameter int                     MAX_RATIO    = 255
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_div_en,
    input  logic                   i_cfg_valid,
    input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
    output logic                   o_cfg_ready,
    output logic                   o_cfg_done,
    output logic                   o_cfg_err,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output div_state_e             o_dbg_state
);

`ifdef DIV_RATIO_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    localparam int TIMER_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [TIMER_W-1:0] DRAIN_LOAD  = TIMER_W'(DRAIN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(DIV_SETTLE_CYCLES - 1);

    div_state_e             state_q, state_d;
    logic [RATIO_WIDTH-1:0] pending_q, pending_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic                   clk_en_q;
    logic                   done_q, done_d;
    logic                   err_q;
    logic                   accept;
    logic                   ratio_bad;
    logic                   reject;
    logic                   take;
    logic                   timer_load;
    logic [TIMER_W-1:0]     timer_val;
    logic                   timer_zero;

    assign o_cfg_ready = (state_q == ST_DISABLED) || (state_q == ST_RUN);
    assign accept      = i_cfg_valid && o_cfg_ready;
    assign ratio_bad   = (int'(i_cfg_ratio) < MIN_RATIO) || (int'(i_cfg_ratio) > MAX_RATIO);
    assign reject      = RANGE_CHECK_EN && ratio_bad;
    assign take        = accept && !reject;

    div_wait_timer #(
        .W (TIMER_W)
    ) u_timer (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // Next-state, pending capture, ratio load and done pulse decode.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        ratio_d    = ratio_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_val  = DRAIN_LOAD;
        if (take) begin
            pending_d = i_cfg_ratio;
        end
        unique case (state_q)
            ST_DISABLED: begin
                if (take) begin
                    state_d = ST_LOAD;
                end else if (!accept && i_div_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (take) begin
                    state_d    = ST_DRAIN;
                    timer_load = 1'b1;
                    timer_val  = DRAIN_LOAD;
                end else if (!accept && !i_div_en) begin
                    state_d = ST_DISABLED;
                end
            end
            ST_DRAIN: begin
                if (timer_zero) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ratio_d    = pending_q;
                state_d    = ST_SETTLE;
                timer_load = 1'b1;
                timer_val  = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_d = i_div_en ? ST_RUN : ST_DISABLED;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_DISABLED;
            end
        endcase
    end

    // State and output registers; the enable follows the next state.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_DISABLED;
            pending_q <= RESET_RATIO;
            ratio_q   <= RESET_RATIO;
            clk_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ratio_q   <= ratio_d;
            clk_en_q  <= (state_d == ST_RUN);
            done_q    <= done_d;
            err_q     <= accept && reject;
        end
    end

    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_cfg_done  = done_q;
    assign o_cfg_err   = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: doc/div_ratio_ctrl.md
# div_ratio_ctrl

Configuration front-end that sits directly upstream of the integer clock divider and owns its `i_div_ratio` and `i_clk_en` inputs. It accepts ratio updates from the register file over a valid/ready handshake and takes the divider offline for a fixed drain window. It then loads the new ratio, waits for the divider to register it, and restores the enable. This keeps every ratio change sequenced the same way, so the divided clock never sees a mid-period ratio swap.

## Interface
- `RATIO_WIDTH`, 8, width of the ratio bus; matches the divider's ratio width.
- `RESET_RATIO`, 8'd1, value of `o_div_ratio` after reset.
- `DRAIN_CYCLES`, 4, number of ref cycles `o_clk_en` is held low before a load; must be ≥1.
- `MIN_RATIO`, 2, lowest legal ratio; used only with the range-check macro.
- `MAX_RATIO`, 255, highest legal ratio; used only with the range-check macro.
- `i_ref_clk  in  1  reference clock`
- `i_rst_n  in  1  reset, asynchronous, active-low`
- `i_div_en  in  1  level request from the register file to run the divider`
- `i_cfg_valid  in  1  new-ratio request`
- `i_cfg_ratio  in  RATIO_WIDTH  requested ratio`
- `o_cfg_ready  out  1  request can be accepted this cycle`
- `o_cfg_done  out  1  one-cycle pulse: the accepted ratio is in effect`
- `o_cfg_err  out  1  one-cycle pulse: the request was rejected`
- `o_div_ratio  out  RATIO_WIDTH  to the divider's `i_div_ratio`; registered`
- `o_clk_en  out  1  to the divider's `i_clk_en`; registered`

## Operation
- **States:** DISABLED, RUN, DRAIN, LOAD, SETTLE.
- **Reset values:** state DISABLED, `o_div_ratio`=`RESET_RATIO`, `o_clk_en`=0, `o_cfg_done`=0, `o_cfg_err`=0.
- **Ready:** `o_cfg_ready` = (state ∈ {DISABLED, RUN}). It is decoded from the state, so it reads 1 out of reset.
- **Accept:** a request is accepted when `i_cfg_valid` && `o_cfg_ready` at a rising edge. `i_cfg_ratio` is then captured into a pending register.
- **DISABLED:**
  - Accept → LOAD.
  - Otherwise, if `i_div_en`=1 → RUN.
- **RUN:**
  - Accept → DRAIN.
  - Otherwise, if `i_div_en`=0 → DISABLED.
- **DRAIN:** `o_clk_en`=0 for exactly `DRAIN_CYCLES` cycles, then → LOAD.
- **LOAD:** `o_div_ratio` ← pending for one cycle, then → SETTLE.
- **SETTLE:** lasts 2 cycles; the divider registers its ratio one cycle after load.
  - Exit → RUN if `i_div_en`=1, else → DISABLED.
  - `o_cfg_done` pulses on the exit edge.
- **`o_clk_en`:** registered, equal to (next state == RUN). It is never high in DRAIN, LOAD or SETTLE.
- **Simultaneous events:**
  - Accept in RUN in the same cycle `i_div_en` falls: the accept wins → DRAIN. SETTLE then exits to DISABLED.
  - `i_div_en` toggling during DRAIN, LOAD or SETTLE is only sampled at SETTLE exit.
- **Back-pressure:** `i_cfg_valid` held high while `o_cfg_ready`=0 is ignored. The requester must hold valid and data stable until accepted.
- **Reset mid-sequence:** returns to DISABLED with `o_div_ratio`=`RESET_RATIO`. The pending request is discarded and no done pulse is issued.

## Timing
- Accept at edge N from RUN:
  - `o_clk_en`=0 from N+1.
  - `o_div_ratio` updates at N+1+`DRAIN_CYCLES`.
  - `o_cfg_done`=1 and `o_clk_en`=1 at N+3+`DRAIN_CYCLES`.
- Accept at edge N from DISABLED: `o_div_ratio` updates at N+1; `o_cfg_done` at N+3.
- Enable/disable via `i_div_en` alone takes 1 cycle.
- Drain counter width is $clog2(`DRAIN_CYCLES`+1). It loads `DRAIN_CYCLES`-1 on DRAIN entry and counts down to 0.

## Configuration
- Macro `DIV_RATIO_RANGE_CHECK_EN`.
- **Defined:** a request with `i_cfg_ratio` < `MIN_RATIO` or > `MAX_RATIO` is consumed (handshake completes) but not applied.
  - `o_cfg_err` pulses on the cycle after the accept edge.
  - State, `o_div_ratio` and `o_clk_en` are unchanged.
- **Undefined:** every ratio is applied, including 0 and 1; the divider bypasses itself for those. `o_cfg_err` is tied to 0.

## Structure
- **Shared package `div_ctrl_pkg`:** state enum type, `DIV_SETTLE_CYCLES`=2, default ratio width constant.
- **Sub-module `div_wait_timer`:** loadable down-counter with a zero flag, reused for the DRAIN and SETTLE waits.

## Test plan
- Reset with `RESET_RATIO`=1 → `o_div_ratio`=1, `o_clk_en`=0, `o_cfg_ready`=1, no pulses.
- In RUN, write ratio 6 with `DRAIN_CYCLES`=4 at edge N → `o_clk_en` low from N+1, ratio=6 at N+5, `o_cfg_done` and `o_clk_en`=1 at N+7.
- In RUN, accept ratio 3 while `i_div_en` falls in the same cycle → ratio=3 applied, done pulse, FSM ends in DISABLED with `o_clk_en`=0.
- With macro defined, write ratio 0 → `o_cfg_err` one pulse, ratio and `o_clk_en` unchanged. Without macro, ratio 0 is applied with a done pulse.
- Hold `i_cfg_valid` through DRAIN with a changed `i_cfg_ratio` → only the first-accepted value is loaded, and the held request is accepted again in RUN.
- Assert `i_rst_n` low during SETTLE → immediate DISABLED, `RESET_RATIO` restored, no `o_cfg_done`.
